// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_controller
// Brief    : UART receive sequencer: line sync, start validation, mid-bit
//            sampling strobes, stop check, buffer load and host status flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_controller #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic data_read,
  output logic serial_sync,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(NUM_DATA_BITS + 1);

  localparam logic [CNT_W-1:0] c_SAMPLE   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [BIT_W-1:0] r_bits;
  logic             r_data_ready;
  logic             r_framing_error;
  logic             r_overrun_error;

  logic w_sample;
  logic w_fall;

  // The counter starts at 0 the cycle after the edge, so HALF-1 lands on E+HALF
  assign w_sample = (r_cnt == c_SAMPLE);
  assign w_fall   = r_prev & ~r_sync2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE || r_state == S_LOAD) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= S_IDLE;
      r_bits          <= '0;
      r_data_ready    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_bits  <= '0;
          end
        end
        S_START: begin
          if (w_sample) begin
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_framing_error <= 1'b0;
              r_state         <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_bits <= r_bits + BIT_W'(1);
            if (r_bits == c_LAST_BIT) begin
              r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (w_sample) begin
            if (r_sync2) begin
              r_state <= S_LOAD;
            end else begin
              r_framing_error <= 1'b1;
              r_state         <= S_IDLE;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // A load in the same cycle as a host read wins over the read
      if (r_state == S_LOAD) begin
        r_data_ready <= 1'b1;
        if (data_read) begin
          r_overrun_error <= 1'b0;
        end else if (r_data_ready) begin
          r_overrun_error <= 1'b1;
        end
      end else if (data_read) begin
        r_data_ready    <= 1'b0;
        r_overrun_error <= 1'b0;
      end
    end
  end

  assign serial_sync   = r_sync2;
  assign shift_strobe  = (r_state == S_DATA) && w_sample;
  assign load_buffer   = (r_state == S_LOAD);
  assign rx_busy       = (r_state != S_IDLE);
  assign data_ready    = r_data_ready;
  assign framing_error = r_framing_error;
  assign overrun_error = r_overrun_error;

endmodule
`default_nettype wire

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Receive-side sequencer for the serial link. It synchronizes the incoming serial line, detects and validates the start bit, and times mid-bit sample points. It pulses shift_strobe into the serial-to-parallel shift register and checks the stop bit. It then commands the packet buffer load and tracks the data_ready, framing and overrun status seen by the host side.

Parameters:
CLKS_PER_BIT, 10, clk cycles per serial bit period (min 4, even).
NUM_DATA_BITS, 8, data bits per frame (1..16); equals the shift register NUM_BITS.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
serial_in  input  1  raw asynchronous serial line (idle high).
data_read  input  1  host acknowledges buffered byte; 1-cycle pulse.
serial_sync  output  1  synchronized line; drives the shift register d_orig.
shift_strobe  output  1  1-cycle pulse at each data-bit sample point; drives the shift register shift_enable.
load_buffer  output  1  1-cycle pulse; host buffer captures the shift register parallel output.
data_ready  output  1  valid unread byte in buffer.
framing_error  output  1  last frame had stop bit = 0.
overrun_error  output  1  byte loaded while previous one unread.
rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: serial_sync=1, internal synchronizer flops=1, edge-detect previous-value flop=1, state=IDLE, counters=0, all pulse outputs=0, data_ready=0, framing_error=0, overrun_error=0, rx_busy=0.
- Synchronizer: 2-flop chain on serial_in; serial_sync is the second flop. A third flop holds the previous serial_sync for edge detection.
- Start edge: in IDLE, the cycle where prev=1 and serial_sync=0 defines cycle E. The next state is START and the bit-period counter clears.
- HALF = CLKS_PER_BIT/2. All sample points are relative to E:
  - start sample at E+HALF;
  - data bit i (i=0..N-1, LSB first) at E+HALF+(i+1)*CLKS_PER_BIT;
  - stop sample at E+HALF+(N+1)*CLKS_PER_BIT.
- States:
  - IDLE: wait for a start edge.
  - START: at the start sample, if serial_sync=1 the start is false; return to IDLE with no pulses and no status change. If serial_sync=0, clear framing_error and go to DATA.
  - DATA: shift_strobe=1 for exactly the sample cycle of each data bit, combinational from state and counter, so the shift register captures serial_sync on that edge. After strobe N, go to STOP.
  - STOP: at the stop sample, if serial_sync=1 go to LOAD. If serial_sync=0, set framing_error and return to IDLE with no load and data_ready unchanged.
  - LOAD: load_buffer=1 for one cycle, then IDLE.
- Latency: load_buffer is asserted at cycle E+HALF+(N+1)*CLKS_PER_BIT+1. data_ready rises the cycle after load_buffer.
- Status flags, set in the LOAD cycle:
  - data_ready <= 1.
  - If data_ready=1 and data_read=0 in that cycle, overrun_error <= 1.
- data_read clears data_ready and overrun_error on the next edge. If data_read and load coincide, the load wins: data_ready stays 1 and no overrun is flagged.
- Line held low after a framing error: no restart until the line returns high and falls again, because restart requires a falling edge.
- Counters:
  - bit-period counter: width clog2(CLKS_PER_BIT), wraps to 0 at CLKS_PER_BIT-1;
  - bit counter: width clog2(NUM_DATA_BITS+1).
  - Both clear on entry to START.
- shift_strobe never asserts outside DATA. A start edge seen in a non-IDLE state is ignored.
- Asserting n_rst mid-frame returns everything to reset values immediately. No pulse is generated on reset release.

Test Plan:
1. Reset, line idle high for 50 cycles -> all outputs 0 and serial_sync=1; no strobes.
2. CLKS_PER_BIT=10, N=8, frame 0xA5 (LSB first) with stop=1 ->
   - 8 shift_strobe pulses at E+15, E+25, …, E+85;
   - load_buffer at E+96;
   - data_ready=1 at E+97;
   - shift register holds 0xA5 with the default shift direction configured for LSB-first.
3. Glitch: line low for 3 cycles then high -> start rejected at E+5; no strobe, no status change; rx_busy returns to 0.
4. Frame with stop bit=0 -> 8 strobes, no load_buffer, framing_error=1 at E+96. The next valid frame clears framing_error at its start sample.
5. Two frames back-to-back without data_read -> second load sets overrun_error=1 and data_ready stays 1. A data_read pulse clears both the next cycle.
6. n_rst pulsed after strobe 4 -> outputs at reset values. The following full frame 0x3C is received correctly, with exactly 8 strobes.
